// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// -----------------------------------------------------------------------------
// Shared definitions for the two-master Wishbone arbiter (wb_arbiter2) and its
// optional watchdog (wb_arb_timer).
//
// Contents:
//   arb_state_e      arbiter FSM states (IDLE, GNT0, GNT1)
//   GNT_NONE/M0/M1   one-hot grant encodings driven on gnt_o
//   DEFAULT_TIMEOUT  default watchdog limit in cycles
//   state_to_gnt()   maps an FSM state onto its grant encoding
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   // Arbiter FSM states. GNTx means master x currently owns the slave.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   // One-hot owner encodings presented on gnt_o.
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   // Watchdog limit used when the instantiating design does not override it.
   localparam int DEFAULT_TIMEOUT = 255;

   // Grant vector for a given FSM state; any unused encoding reads as idle.
   function automatic logic [1:0] state_to_gnt(input arb_state_e s);
      logic [1:0] g;
      case (s)
         GNT0:    g = GNT_M0;
         GNT1:    g = GNT_M1;
         default: g = GNT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// -----------------------------------------------------------------------------
// wb_arb_timer
// -----------------------------------------------------------------------------
// Watchdog for the shared slave port. Counts cycles in which a strobe is
// outstanding without any termination from the slave. When the count reaches
// TIMEOUT a single-cycle timeout pulse is produced and the counter restarts,
// so the arbiter can turn it into an error termination for the owner.
//
// Only instantiated by wb_arbiter2 when WB_ARB_TIMEOUT_EN is defined.
//
// Parameters:
//   TIMEOUT    number of unterminated strobe cycles before a timeout pulse
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   stb_i      strobe currently presented to the slave
//   ack_i      slave acknowledge
//   err_i      slave error
//   clr_i      ownership is changing at the next edge; restart the count
//   timeout_o  single-cycle pulse when the count has reached TIMEOUT
// -----------------------------------------------------------------------------
import wb_arb_pkg::*;

module wb_arb_timer #(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic stb_i,
   input  logic ack_i,
   input  logic err_i,
   input  logic clr_i,
   output logic timeout_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          hit;

   // The count restarts on any termination, on a change of owner and on its
   // own expiry; otherwise it advances once per waiting strobe cycle.
   always_comb begin
      hit     = (count_q == CW'(TIMEOUT));
      count_d = count_q;
      if (clr_i || ack_i || err_i || hit) begin
         count_d = '0;
      end else if (stb_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign timeout_o = hit;

endmodule

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
// -----------------------------------------------------------------------------
// Two-master, one-slave Wishbone arbiter sharing a single BRAM slave port
// between the CPU data master (m0) and the CPU instruction master (m1).
//
// Ownership is registered and held for as long as the owner keeps its cyc
// high. Simultaneous requests from idle are resolved round-robin against the
// most recent owner. When the owner releases cyc while the other master is
// waiting, ownership passes directly with no idle cycle in between. The data
// path and terminations are purely combinational through the grant mux.
//
// Configuration macro:
//   WB_ARB_TIMEOUT_EN  when defined, a watchdog (wb_arb_timer) raises a
//                      one-cycle error to the owner if the slave leaves a
//                      strobe unterminated for TIMEOUT cycles. When not
//                      defined, mx_err_o is a pure pass-through of s_err_i.
//
// Parameters:
//   AW, DW     address and data width
//   TIMEOUT    watchdog limit in cycles (only used with WB_ARB_TIMEOUT_EN)
//
// Ports:
//   wb_clk_i, wb_rst_i          clock (rising edge) and async active-high reset
//   m0_* / m1_*                 master-side Wishbone ports (data / instruction)
//      cyc_i, stb_i, we_i, sel_i, adr_i, dat_i   requests from the master
//      dat_o, ack_o, err_o                       read data and terminations
//   s_*                         slave-side Wishbone port
//      cyc_o, stb_o, we_o, sel_o, adr_o, dat_o   request to the slave
//      dat_i, ack_i, err_i                       read data and terminations
//   gnt_o                       one-hot current owner, 00 when idle
// -----------------------------------------------------------------------------
import wb_arb_pkg::*;

module wb_arbiter2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,

   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,

   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,

   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,

   output logic [1:0]    gnt_o
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_q;
   logic       last_d;
   logic       wdog_timeout;

   // State and last-owner registers. last_q = 1 means m1 owned the slave most
   // recently; it resets to 1 so that m0 wins the first tie after reset.
   // Reset is asynchronous so an in-flight access is abandoned at once.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic. An owner is never pre-empted while its cyc is high.
   // On release, a waiting peer takes over at the very next edge; from idle,
   // a tie goes to whichever master did not own the slave last. The last
   // owner is updated on entry to a grant state.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_d = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_d = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_d == GNT0) begin
         last_d = 1'b0;
      end else if (state_d == GNT1) begin
         last_d = 1'b1;
      end
   end

   // Grant mux. The owner's request is forwarded to the slave unchanged and
   // the slave's terminations go back to the owner only; the non-owner sees
   // its ack/err held low, which stalls it until it is granted. While idle
   // the slave sees an all-zero request.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state_q)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | wdog_timeout;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | wdog_timeout;
         end
         default: begin
         end
      endcase
   end

   // Read data is broadcast to both masters; each qualifies it with its ack.
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   assign gnt_o = state_to_gnt(state_q);

`ifdef WB_ARB_TIMEOUT_EN
   // Watchdog on the shared port. A change of owner restarts the count so a
   // newly granted master gets its full TIMEOUT window.
   wb_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .stb_i     (s_stb_o),
      .ack_i     (s_ack_i),
      .err_i     (s_err_i),
      .clr_i     (state_d != state_q),
      .timeout_o (wdog_timeout)
   );
`else
   // Without the watchdog the error path is a plain pass-through.
   assign wdog_timeout = 1'b0;

   // TIMEOUT is consumed only by the watchdog; this empty branch keeps the
   // parameter referenced in builds that leave the watchdog out.
   if (TIMEOUT < 1) begin : g_timeout_ref
   end
`endif

endmodule
